// File: rtl/rom_download_writer.sv
// Captures toggle-strobed download words into a small FIFO and writes them to SDRAM via req/ack.
// Optional running write checksum when ROM_DOWNLOAD_WRITER_CHECKSUM_EN is defined.
//
// state | meaning
// IDLE  | no write outstanding; launches the FIFO head when one is present
// REQ   | ram_req held with stable addr/data until ram_ack pops the head
module rom_download_writer #(
  parameter int ADDR_WIDTH = 23,
  parameter int FIFO_AW    = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  data_download,
  input  logic                  data_in_strobe,
  input  logic [15:0]           data_in_reg,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  output logic                  ram_req,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [15:0]           ram_din,
  output logic [1:0]            ram_be,
  input  logic                  ram_ack,
`ifdef ROM_DOWNLOAD_WRITER_CHECKSUM_EN
  output logic [15:0]           checksum,
`endif
  output logic                  busy,
  output logic                  overflow,
  output logic                  done
);

  localparam int DEPTH = 2**FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t                      r_state;
  logic                        r_strobe_d;
  logic                        r_dl_d;
  logic [ADDR_WIDTH+15:0]      r_mem [DEPTH];
  logic [FIFO_AW-1:0]          r_wptr;
  logic [FIFO_AW-1:0]          r_rptr;
  logic [FIFO_AW:0]            r_count;
  logic                        r_req;
  logic [ADDR_WIDTH-1:0]       r_addr;
  logic [15:0]                 r_din;
  logic [1:0]                  r_be;
  logic                        r_overflow;
  logic                        r_done;
  logic                        r_done_pending;

  logic w_push, w_pop, w_full, w_empty, w_wr, w_dl_rise, w_dl_fall;

  assign w_push    = data_in_strobe ^ r_strobe_d;
  assign w_pop     = (r_state == S_REQ) && ram_ack;
  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  // When full, a same-cycle pop frees the slot the push lands in.
  assign w_wr      = w_push && (!w_full || w_pop);
  assign w_dl_rise = data_download && !r_dl_d;
  assign w_dl_fall = !data_download && r_dl_d;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= {data_addr, data_in_reg};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_strobe_d <= 1'b0;
      r_dl_d     <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else begin
      r_strobe_d <= data_in_strobe;
      r_dl_d     <= data_download;
      if (w_wr)  r_wptr <= r_wptr + FIFO_AW'(1);
      if (w_pop) r_rptr <= r_rptr + FIFO_AW'(1);
      if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_din   <= '0;
      r_be    <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            {r_addr, r_din} <= r_mem[r_rptr];
            r_req   <= 1'b1;
            r_be    <= 2'b11;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (ram_ack) begin
            r_req   <= 1'b0;
            r_be    <= 2'b00;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow     <= 1'b0;
      r_done         <= 1'b0;
      r_done_pending <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_dl_rise) begin
        r_overflow     <= 1'b0;
        r_done_pending <= 1'b0;
      end else if (w_dl_fall) begin
        r_done_pending <= 1'b1;
      end else if (r_done_pending && w_empty && (r_state == S_IDLE)) begin
        r_done         <= 1'b1;
        r_done_pending <= 1'b0;
      end
      // A drop in the same cycle as a new download start is still reported.
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

`ifdef ROM_DOWNLOAD_WRITER_CHECKSUM_EN
  logic [15:0] r_checksum;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       r_checksum <= '0;
    else if (w_dl_rise) r_checksum <= '0;
    else if (w_pop)     r_checksum <= r_checksum + r_din;
  end

  assign checksum = r_checksum;
`endif

  assign ram_req  = r_req;
  assign ram_addr = r_addr;
  assign ram_din  = r_din;
  assign ram_be   = r_be;
  assign overflow = r_overflow;
  assign done     = r_done;
  assign busy     = data_download | !w_empty | (r_state != S_IDLE);

endmodule

// File: doc/rom_download_writer.md
Name: rom_download_writer

Overview:
- Sits directly downstream of the SPI data interface's file-download path (UIO_FILE_TX_DAT words).
- Detects each toggle of the upstream word strobe and captures the 16-bit word with its word address into a small FIFO.
- Drains the FIFO into the SDRAM controller through a level request / single-cycle acknowledge handshake.
- Reports busy, overflow and download-complete status so the top level can hold the CPU in reset during a ROM or cartridge load.

Parameters:
- ADDR_WIDTH, 23: word address width (byte address bits [23:1]).
- FIFO_AW, 2: FIFO address bits; depth = 2**FIFO_AW entries (default 4).

Ports:
- clk  in  1: system clock, same domain as the upstream data interface.
- reset_n  in  1: asynchronous active-low reset.
- data_download  in  1: level, high while a file transfer is in progress.
- data_in_strobe  in  1: toggle; each change marks one new valid word.
- data_in_reg  in  16: word, valid in the cycle the toggle is seen.
- data_addr  in  ADDR_WIDTH: word address, valid with data_in_reg.
- ram_req  out  1: write request, held high until acknowledged.
- ram_addr  out  ADDR_WIDTH: write word address.
- ram_din  out  16: write data.
- ram_be  out  2: byte enables, always 2'b11 when ram_req is high.
- ram_ack  in  1: one-cycle acknowledge from the SDRAM controller.
- busy  out  1: data_download | FIFO not empty | FSM not IDLE.
- overflow  out  1: sticky, set when a word is dropped because the FIFO was full.
- done  out  1: one-cycle pulse when a download has fully drained.

Behaviour:
Reset (reset_n low, asynchronous):
- ram_req=0, ram_addr=0, ram_din=0, ram_be=0, overflow=0, done=0.
- FIFO empty, FSM in IDLE, strobe history register = 0, done_pending=0.
- Asserting reset mid-write abandons the request immediately; the SDRAM controller must tolerate ram_req dropping.

Strobe detect:
- strobe_d registers data_in_strobe every clk.
- push = (data_in_strobe ^ strobe_d) combinationally; data_in_reg and data_addr are sampled on that same edge.

FIFO (registered pointers, count 0..DEPTH):
- push while not full: write {data_addr, data_in_reg} at wptr; wptr increments modulo DEPTH.
- push while full: word dropped, overflow <= 1.
- Simultaneous push and pop when full: both take effect; count unchanged; no overflow.
- Pointers wrap naturally at 2**FIFO_AW.

FSM:
- IDLE: if FIFO not empty, load ram_addr/ram_din from the head entry, set ram_req=1 and ram_be=2'b11, go to REQ.
- REQ: hold ram_req and all outputs stable until ram_ack=1. On ack: pop the head, ram_req=0, ram_be=0, go to IDLE.
- ram_ack while in IDLE is ignored.
- Minimum spacing between requests is 1 idle cycle.

Latency:
- Toggle seen at edge N: entry present after edge N; ram_req high after edge N+1.

Download control:
- Rising edge of data_download: clear overflow; clear checksum (see Optional Feature); clear done_pending. The FIFO is not flushed.
- Falling edge of data_download: done_pending <= 1.
- When done_pending=1, FIFO empty and FSM in IDLE: done=1 for one cycle, then done_pending <= 0.
- Strobes with data_download low are still accepted and written.

Optional Feature:
- Macro: ROM_DOWNLOAD_WRITER_CHECKSUM_EN.
- Defined: adds output port checksum [15:0]. On every ram_ack, checksum <= checksum + ram_din, modulo 2^16. Reset value 0; also cleared on the rising edge of data_download.
- Undefined: no checksum port or logic; behaviour otherwise identical.

Test Plan:
- Single word: download=1, toggle strobe with data=16'hA55A, addr=23'h700000 → ram_req high 2 edges later with ram_addr=23'h700000, ram_din=16'hA55A, ram_be=2'b11; hold ack off 5 cycles → outputs stable; ack → ram_req low next edge.
- Burst: 6 toggles on consecutive cycles, ram_ack withheld → first 4 stored, overflow=1, then acks → exactly 4 writes in order; overflow stays 1 until the next download rise.
- Full-FIFO concurrency: FIFO full, ack and push in the same cycle → no overflow, 4 entries remain, next write is the correct successor word.
- Completion: data_download falls with 3 words queued → done stays 0 until the third ack, then pulses exactly 1 cycle while busy falls.
- Reset: reset_n low while ram_req=1 and 2 words queued → ram_req=0 immediately; after release no writes issue, and a new toggle is written normally.
- Checksum (macro defined): write words 16'hFFFF, 16'h0002 → checksum=16'h0001; a new download rise → checksum=0.
